// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared op/status codes, FSM states and width defaults for the ATM account arbiter
package atm_pkg;

  localparam int REG_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    OP_BAL  = 2'b00,
    OP_DEP  = 2'b01,
    OP_WD   = 2'b10,
    OP_XFER = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    STS_OK    = 2'b00,
    STS_INSUF = 2'b01,
    STS_OVF   = 2'b10,
    STS_BAD   = 2'b11
  } status_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_SRC,
    S_CAP_SRC,
    S_RD_DST,
    S_CAP_DST,
    S_EXEC,
    S_WR_SRC,
    S_WR_DST,
    S_RESP
  } state_e;

endpackage

// File: rtl/atm_rr_picker.sv
// rtl/atm_rr_picker.sv - one-hot round-robin select; pointer moves past the served requester on i_adv
module atm_rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_adv,
  input  logic [PTR_W-1:0] i_adv_idx,
  output logic [N_REQ-1:0] o_pick,
  output logic [PTR_W-1:0] o_pick_idx
);

  logic [PTR_W-1:0] r_ptr;
  logic             w_hit;

  always_comb begin
    o_pick     = '0;
    o_pick_idx = '0;
    w_hit      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_hit && i_req[(int'(r_ptr) + i) % N_REQ]) begin
        w_hit = 1'b1;
        o_pick[(int'(r_ptr) + i) % N_REQ] = 1'b1;
        o_pick_idx = PTR_W'((int'(r_ptr) + i) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (i_adv_idx == PTR_W'(N_REQ - 1)) ? '0 : i_adv_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/atm_account_arbiter.sv
// rtl/atm_account_arbiter.sv - round-robin locked read-modify-write sequencer onto one account store
// Optional ATM_ARB_TXN_CNT_EN adds txn_count, counting successful non-balance transactions.
module atm_account_arbiter
  import atm_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int IDX_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [2*N_REQ-1:0]         req_op,
  input  logic [IDX_W*N_REQ-1:0]     req_src,
  input  logic [IDX_W*N_REQ-1:0]     req_dst,
  input  logic [REG_WIDTH*N_REQ-1:0] req_amount,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic [1:0]                 rsp_status,
  output logic [REG_WIDTH-1:0]       rsp_balance,
  output logic [REG_WIDTH-1:0]       rsp_dst_balance,
  output logic [IDX_W-1:0]           mem_addr,
  output logic                       mem_rd_en,
  input  logic [REG_WIDTH-1:0]       mem_rdata,
  output logic                       mem_wr_en,
`ifdef ATM_ARB_TXN_CNT_EN
  output logic [REG_WIDTH-1:0]       mem_wdata,
  output logic [15:0]                txn_count
`else
  output logic [REG_WIDTH-1:0]       mem_wdata
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e               r_state, w_next;
  op_e                  r_op;
  logic [IDX_W-1:0]     r_src, r_dst;
  logic [REG_WIDTH-1:0] r_amt, r_bal_src, r_bal_dst, r_new_src, r_new_dst;
  logic [PTR_W-1:0]     r_idx;
  logic [N_REQ-1:0]     r_gnt, r_done;
  status_e              r_status;
  logic [REG_WIDTH-1:0] r_rsp_bal, r_rsp_dst, r_mem_wdata;
  logic [IDX_W-1:0]     r_mem_addr;
  logic                 r_mem_rd, r_mem_wr;

  logic [N_REQ-1:0]     w_pick;
  logic [PTR_W-1:0]     w_pick_idx;
  logic [IDX_W-1:0]     w_pick_src;
  logic [REG_WIDTH:0]   w_sum_src, w_sum_dst, w_diff;
  status_e              w_status;
  logic [REG_WIDTH-1:0] w_new_src, w_new_dst;
  logic [IDX_W-1:0]     w_addr_nxt;
  logic [REG_WIDTH-1:0] w_wdata_nxt;
  logic                 w_rd_nxt, w_wr_nxt;

  atm_rr_picker #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_picker (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req),
    .i_adv      (r_state == S_RESP),
    .i_adv_idx  (r_idx),
    .o_pick     (w_pick),
    .o_pick_idx (w_pick_idx)
  );

  assign w_pick_src = req_src[w_pick_idx*IDX_W +: IDX_W];

  // Widened by one bit: the carry flags overflow, the borrow flags insufficiency.
  assign w_sum_src = {1'b0, r_bal_src} + {1'b0, r_amt};
  assign w_sum_dst = {1'b0, r_bal_dst} + {1'b0, r_amt};
  assign w_diff    = {1'b0, r_bal_src} - {1'b0, r_amt};

  always_comb begin
    w_status  = STS_OK;
    w_new_src = r_bal_src;
    w_new_dst = r_bal_dst;
    case (r_op)
      OP_DEP: begin
        if (r_amt == '0)       w_status = STS_BAD;
        else if (w_sum_src[REG_WIDTH]) w_status = STS_OVF;
        else                   w_new_src = w_sum_src[REG_WIDTH-1:0];
      end
      OP_WD: begin
        if (r_amt == '0)       w_status = STS_BAD;
        else if (w_diff[REG_WIDTH]) w_status = STS_INSUF;
        else                   w_new_src = w_diff[REG_WIDTH-1:0];
      end
      OP_XFER: begin
        if (r_amt == '0 || r_src == r_dst) w_status = STS_BAD;
        else if (w_diff[REG_WIDTH])        w_status = STS_INSUF;
        else if (w_sum_dst[REG_WIDTH])     w_status = STS_OVF;
        else begin
          w_new_src = w_diff[REG_WIDTH-1:0];
          w_new_dst = w_sum_dst[REG_WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (|req) w_next = S_RD_SRC;
      S_RD_SRC:  w_next = S_CAP_SRC;
      S_CAP_SRC: w_next = (r_op == OP_XFER) ? S_RD_DST : S_EXEC;
      S_RD_DST:  w_next = S_CAP_DST;
      S_CAP_DST: w_next = S_EXEC;
      S_EXEC:    w_next = (r_op == OP_BAL || w_status != STS_OK) ? S_RESP : S_WR_SRC;
      S_WR_SRC:  w_next = (r_op == OP_XFER) ? S_WR_DST : S_RESP;
      S_WR_DST:  w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Read strobes lead their state so data lands in CAP_*; write strobes follow their WR_* state.
  always_comb begin
    w_addr_nxt  = '0;
    w_wdata_nxt = '0;
    w_rd_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    if (w_next == S_RD_SRC) begin
      w_rd_nxt   = 1'b1;
      w_addr_nxt = w_pick_src;
    end else if (w_next == S_RD_DST) begin
      w_rd_nxt   = 1'b1;
      w_addr_nxt = r_dst;
    end else if (r_state == S_WR_SRC) begin
      w_wr_nxt    = 1'b1;
      w_addr_nxt  = r_src;
      w_wdata_nxt = r_new_src;
    end else if (r_state == S_WR_DST) begin
      w_wr_nxt    = 1'b1;
      w_addr_nxt  = r_dst;
      w_wdata_nxt = r_new_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_BAL;
      r_src       <= '0;
      r_dst       <= '0;
      r_amt       <= '0;
      r_idx       <= '0;
      r_bal_src   <= '0;
      r_bal_dst   <= '0;
      r_new_src   <= '0;
      r_new_dst   <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_status    <= STS_OK;
      r_rsp_bal   <= '0;
      r_rsp_dst   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_mem_rd    <= w_rd_nxt;
      r_mem_wr    <= w_wr_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_done      <= (w_next == S_RESP) ? r_gnt : '0;
      case (r_state)
        S_IDLE: if (w_next == S_RD_SRC) begin
          r_gnt <= w_pick;
          r_idx <= w_pick_idx;
          r_op  <= op_e'(req_op[w_pick_idx*2 +: 2]);
          r_src <= w_pick_src;
          r_dst <= req_dst[w_pick_idx*IDX_W +: IDX_W];
          r_amt <= req_amount[w_pick_idx*REG_WIDTH +: REG_WIDTH];
        end
        S_CAP_SRC: r_bal_src <= mem_rdata;
        S_CAP_DST: r_bal_dst <= mem_rdata;
        S_EXEC: begin
          r_status  <= w_status;
          r_new_src <= w_new_src;
          r_new_dst <= w_new_dst;
          r_rsp_bal <= w_new_src;
          r_rsp_dst <= (r_op == OP_XFER) ? w_new_dst : '0;
        end
        S_RESP: r_gnt <= '0;
        default: ;
      endcase
    end
  end

`ifdef ATM_ARB_TXN_CNT_EN
  logic [15:0] r_txn_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txn_cnt <= '0;
    end else if (r_state == S_RESP && r_status == STS_OK && r_op != OP_BAL) begin
      r_txn_cnt <= r_txn_cnt + 16'd1;
    end
  end

  assign txn_count = r_txn_cnt;
`endif

  assign gnt             = r_gnt;
  assign done            = r_done;
  assign rsp_status      = r_status;
  assign rsp_balance     = r_rsp_bal;
  assign rsp_dst_balance = r_rsp_dst;
  assign mem_addr        = r_mem_addr;
  assign mem_rd_en       = r_mem_rd;
  assign mem_wr_en       = r_mem_wr;
  assign mem_wdata       = r_mem_wdata;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// tb/tb_atm_account_arbiter.sv - directed self-checking bench for atm_account_arbiter with a behavioural account store
module tb_atm_account_arbiter;

  localparam int N_REQ = 4;
  localparam int RW    = 12;
  localparam int IW    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req;
  logic [2*N_REQ-1:0]    req_op;
  logic [IW*N_REQ-1:0]   req_src, req_dst;
  logic [RW*N_REQ-1:0]   req_amount;
  logic [N_REQ-1:0]      gnt, done;
  logic [1:0]            rsp_status;
  logic [RW-1:0]         rsp_balance, rsp_dst_balance, mem_rdata, mem_wdata;
  logic [IW-1:0]         mem_addr;
  logic                  mem_rd_en, mem_wr_en;
`ifdef ATM_ARB_TXN_CNT_EN
  logic [15:0]           txn_count;
`endif

  logic [RW-1:0] mem [4];
  logic          preset;
  int            wr_cnt = 0;
  int            multi_gnt = 0;
  int            total = 0;
  int            bad = 0;
  int            cyc;

  atm_account_arbiter #(.N_REQ(N_REQ), .REG_WIDTH(RW), .IDX_W(IW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_op          (req_op),
    .req_src         (req_src),
    .req_dst         (req_dst),
    .req_amount      (req_amount),
    .gnt             (gnt),
    .done            (done),
    .rsp_status      (rsp_status),
    .rsp_balance     (rsp_balance),
    .rsp_dst_balance (rsp_dst_balance),
    .mem_addr        (mem_addr),
    .mem_rd_en       (mem_rd_en),
    .mem_rdata       (mem_rdata),
    .mem_wr_en       (mem_wr_en),
`ifdef ATM_ARB_TXN_CNT_EN
    .mem_wdata       (mem_wdata),
    .txn_count       (txn_count)
`else
    .mem_wdata       (mem_wdata)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preset) begin
      mem[0] <= 12'h457;
      mem[1] <= 12'h8AE;
      mem[2] <= 12'hD05;
      mem[3] <= 12'h000;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) if ($countones(gnt) > 1) multi_gnt <= multi_gnt + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_preset();
    preset = 1'b1;
    @(negedge clk);
    preset = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [1:0] op, input logic [IW-1:0] src,
                         input logic [IW-1:0] dst, input logic [RW-1:0] amt);
    req[k]                = 1'b1;
    req_op[2*k +: 2]      = op;
    req_src[IW*k +: IW]   = src;
    req_dst[IW*k +: IW]   = dst;
    req_amount[RW*k +: RW] = amt;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (done == '0 && c < 40);
  endtask

  task automatic run_txn(input string tag, input int k, input logic [1:0] op, input logic [IW-1:0] src,
                         input logic [IW-1:0] dst, input logic [RW-1:0] amt, input int lat,
                         input int st, input int bal, input bit chk_dst, input int dbal, input int wrs);
    int w0;
    int c;
    w0 = wr_cnt;
    set_req(k, op, src, dst, amt);
    wait_done(c);
    chk({tag, "_lat"}, c, lat);
    chk({tag, "_done"}, int'(done), 1 << k);
    chk({tag, "_gnt"}, int'(gnt), 1 << k);
    chk({tag, "_status"}, int'(rsp_status), st);
    chk({tag, "_bal"}, int'(rsp_balance), bal);
    if (chk_dst) chk({tag, "_dstbal"}, int'(rsp_dst_balance), dbal);
    req[k] = 1'b0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_gnt_drop"}, int'(gnt), 0);
    chk({tag, "_writes"}, wr_cnt - w0, wrs);
  endtask

  initial begin
    rst = 1'b1; preset = 1'b0;
    req = '0; req_op = '0; req_src = '0; req_dst = '0; req_amount = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_status", int'(rsp_status), 0);
    chk("rst_bal", int'(rsp_balance), 0);
    chk("rst_rd", int'(mem_rd_en), 0);
    chk("rst_wr", int'(mem_wr_en), 0);
    rst = 1'b0;

    do_preset();
    run_txn("dep", 0, 2'b01, 2'd0, 2'd0, 12'h010, 5, 0, 'h467, 1, 0, 1);
    chk("dep_mem0", int'(mem[0]), 'h467);

    do_preset();
    run_txn("wd_insuf", 1, 2'b10, 2'd1, 2'd0, 12'h8AF, 4, 1, 'h8AE, 1, 0, 0);
    chk("wd_insuf_mem1", int'(mem[1]), 'h8AE);

    do_preset();
    run_txn("xfer", 2, 2'b11, 2'd2, 2'd0, 12'h100, 8, 0, 'hC05, 1, 'h557, 2);
    chk("xfer_mem2", int'(mem[2]), 'hC05);
    chk("xfer_mem0", int'(mem[0]), 'h557);

    do_preset();
    run_txn("dep_ovf", 3, 2'b01, 2'd2, 2'd0, 12'hFFF, 4, 2, 'hD05, 1, 0, 0);
    run_txn("xfer_same", 0, 2'b11, 2'd1, 2'd1, 12'h005, 6, 3, 'h8AE, 0, 0, 0);
    run_txn("wd_exact", 1, 2'b10, 2'd1, 2'd0, 12'h8AE, 5, 0, 'h000, 1, 0, 1);
    chk("wd_exact_mem1", int'(mem[1]), 'h000);

    do_preset();
    run_txn("dep_zero", 2, 2'b01, 2'd0, 2'd0, 12'h000, 4, 3, 'h457, 1, 0, 0);
    run_txn("bal", 3, 2'b00, 2'd2, 2'd0, 12'h000, 4, 0, 'hD05, 1, 0, 0);
    run_txn("xfer_ovf", 0, 2'b11, 2'd1, 2'd2, 12'h400, 6, 2, 'h8AE, 0, 0, 0);
    chk("xfer_ovf_mem2", int'(mem[2]), 'hD05);
`ifdef ATM_ARB_TXN_CNT_EN
    chk("txn_count", int'(txn_count), 3);
`endif

    do_reset();
    do_preset();
    for (int k = 0; k < N_REQ; k++) set_req(k, 2'b00, IW'(k), 2'd0, 12'h000);
    for (int i = 0; i < 8; i++) begin
      wait_done(cyc);
      chk($sformatf("rr%0d_lat", i), cyc, (i == 0) ? 4 : 5);
      chk($sformatf("rr%0d_gnt", i), int'(gnt), 1 << (i % 4));
      case (i % 4)
        0: chk($sformatf("rr%0d_bal", i), int'(rsp_balance), 'h457);
        1: chk($sformatf("rr%0d_bal", i), int'(rsp_balance), 'h8AE);
        2: chk($sformatf("rr%0d_bal", i), int'(rsp_balance), 'hD05);
        default: chk($sformatf("rr%0d_bal", i), int'(rsp_balance), 'h000);
      endcase
    end
    req = '0;
    @(negedge clk);
    @(negedge clk);

    do_reset();
    do_preset();
    set_req(0, 2'b11, 2'd0, 2'd1, 12'h010);
    repeat (7) @(negedge clk);
    chk("rstmid_gnt", int'(gnt), 1);
    chk("rstmid_wr_src", int'(mem_wr_en), 1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("rstmid_gnt0", int'(gnt), 0);
    chk("rstmid_done0", int'(done), 0);
    chk("rstmid_wr0", int'(mem_wr_en), 0);
    chk("rstmid_rd0", int'(mem_rd_en), 0);
    chk("rstmid_addr0", int'(mem_addr), 0);
    chk("rstmid_wdata0", int'(mem_wdata), 0);
    chk("rstmid_bal0", int'(rsp_balance), 0);
`ifdef ATM_ARB_TXN_CNT_EN
    chk("rstmid_txn0", int'(txn_count), 0);
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_mem0", int'(mem[0]), 'h447);
    chk("rstmid_mem1", int'(mem[1]), 'h8AE);

    chk("gnt_onehot", multi_gnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atm_account_arbiter.md
Name: atm_account_arbiter

Overview:
- Arbitrates several ATM terminal front-ends (requesters) onto one shared single-port account-balance memory.
- Sequences each granted transaction as a locked read-modify-write: balance, deposit, withdraw or transfer.
- Performs the sufficiency and overflow checks, then returns status and the resulting balances to the winner.
- Sits between the per-terminal session FSMs and the account store, so no two terminals ever interleave updates to the store.

Parameters:
- N_REQ, 4, number of requesters.
- REG_WIDTH, 12, balance/amount width.
- IDX_W, 2, account index width (memory depth 2**IDX_W).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level.
- req_op  in  2*N_REQ  packed op per requester: 00 balance, 01 deposit, 10 withdraw, 11 transfer.
- req_src  in  IDX_W*N_REQ  packed source account index.
- req_dst  in  IDX_W*N_REQ  packed destination index (transfer only).
- req_amount  in  REG_WIDTH*N_REQ  packed amount.
- gnt  out  N_REQ  one-hot grant, held for the whole transaction.
- done  out  N_REQ  one-cycle completion pulse to the winner.
- rsp_status  out  2  00 OK, 01 INSUFFICIENT, 10 OVERFLOW, 11 BAD_REQ; valid with done.
- rsp_balance  out  REG_WIDTH  source balance after the op; valid with done.
- rsp_dst_balance  out  REG_WIDTH  destination balance after a transfer, else 0.
- mem_addr  out  IDX_W  memory address.
- mem_rd_en  out  1  read strobe; mem_rdata is valid the following cycle.
- mem_rdata  in  REG_WIDTH  read data.
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  REG_WIDTH  write data.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE and the round-robin pointer is 0.
- Every output is registered.
- FSM states:
  - IDLE: if any req is high, select the winner by round-robin, latch its op/src/dst/amount and assert gnt; go to RD_SRC.
  - RD_SRC: issue mem_rd_en with addr=src.
  - CAP_SRC: capture the source balance. Go to RD_DST if op is transfer, else to EXEC.
  - RD_DST: issue mem_rd_en with addr=dst.
  - CAP_DST: capture the destination balance.
  - EXEC: compute the result and status.
  - WR_SRC: write the new source balance.
  - WR_DST: write the new destination balance (transfer only).
  - RESP: pulse done, drop gnt, advance the pointer; go to IDLE.
- EXEC skips both write states, going straight to RESP, for balance ops and whenever the status is not OK.
- Latency, counted from the IDLE cycle that samples req:
  - balance: done is high at cycle 4.
  - deposit/withdraw OK: done at cycle 5.
  - transfer OK: done at cycle 8.
  - any non-OK status: done at cycle 4 (deposit/withdraw) or cycle 6 (transfer).
- Arithmetic uses REG_WIDTH+1 bits internally:
  - Deposit: OVERFLOW if bal+amt > 2**REG_WIDTH-1.
  - Withdraw/transfer: INSUFFICIENT if amt > bal; amt == bal is allowed and leaves 0.
  - Transfer: OVERFLOW if dst+amt overflows; nothing is written.
- BAD_REQ is returned, with no writes, when amt == 0 for deposit/withdraw/transfer, or when a transfer has src == dst.
- Round-robin: after serving requester k, requester k+1 mod N_REQ has highest priority. Requests arriving mid-transaction wait.
- The winner must hold its payload stable until done. The payload is latched at grant, so later changes are ignored.
- If the winner drops req mid-transaction, the transaction still completes and done still pulses.
- Reset mid-transaction: at the next edge the FSM returns to IDLE, and gnt/done/mem_* go to 0.
  - A partially completed transfer (WR_SRC done, WR_DST not) is not rolled back.
- Back-to-back: a request pending in the RESP cycle is arbitrated in the following IDLE cycle. The minimum gap between transactions is one IDLE cycle.

Optional Feature:
- Macro ATM_ARB_TXN_CNT_EN.
- When defined, the block adds the output txn_count [15:0], reset to 0.
  - It increments in every RESP cycle whose rsp_status is OK and whose op is not balance.
  - It wraps at 0xFFFF.
- When undefined, the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package atm_pkg holds:
  - op codes and status codes;
  - the FSM state enum;
  - the REG_WIDTH default.
- Sub-module atm_rr_picker: combinational one-hot round-robin select from req plus the pointer, with a registered pointer update on an advance strobe.

Test Plan:
- Memory preset is idx0=0x457, idx1=0x8AE, idx2=0xD05 for every scenario below.
- Requester 0 deposits 0x010 into idx0 -> done at cycle 5, status OK, rsp_balance=0x467, memory idx0=0x467.
- Requester 1 withdraws 0x8AF from idx1 -> done at cycle 4, status INSUFFICIENT, rsp_balance=0x8AE, no mem_wr_en.
- Requester 2 transfers 0x100 from idx2 to idx0 -> done at cycle 8, OK, rsp_balance=0xC05, rsp_dst_balance=0x557.
- req=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; never two gnt bits high.
- Deposit of 0xFFF into idx2 -> OVERFLOW. Transfer with src == dst -> BAD_REQ. Neither writes.
- rst asserted during WR_DST of a transfer -> idx0 updated, dst unchanged, all outputs 0 the next cycle; with ATM_ARB_TXN_CNT_EN, txn_count=0.
